scoreboard_generator: RTL and testbench

SCOREBOARD_GENERATOR -- requirements
Module: scoreboard_generator

---
 rtl/scoreboard_generator_pkg.sv | 32 +++
 rtl/scoreboard_generator_counter.sv | 38 +++
 rtl/scoreboard_generator.sv | 119 +++++++++++
 tb/tb_scoreboard_generator.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_generator_pkg.sv
// Shared constants, cell identifiers and the saturating BCD step
// used by the scoreboard generator and its counters.
package scoreboard_generator_pkg;

    localparam int          CELL_W      = 16;
    localparam int          ROW_H       = 10;
    localparam int          DIGIT_W     = 5;
    localparam logic [3:0]  BLANK_DIGIT = 4'hF;
    localparam logic [7:0]  SCORE_MAX   = 8'h99;

    typedef enum logic [2:0] {
        CELL_NONE,
        CELL_P1_TENS,
        CELL_P1_ONES,
        CELL_P2_TENS,
        CELL_P2_ONES
    } cell_e;

    // Packed BCD +1 that holds at 99
    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] s);
        logic [7:0] r;
        if (s == SCORE_MAX) begin
            r = s;
        end else if (s[3:0] == 4'd9) begin
            r = {s[7:4] + 4'd1, 4'd0};
        end else begin
            r = {s[7:4], s[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/scoreboard_generator_counter.sv
// Two-digit saturating BCD score with rising-edge point detection.
// A point request held high across reset release is ignored until it drops.
module bcd_score_counter
    import scoreboard_generator_pkg::*;
(
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic       i_inc,
    input  logic       i_clear,
    output logic [7:0] o_score
);

    logic [7:0] r_score;
    logic       r_prev;
    logic       r_armed;
    logic       w_rise;

    assign w_rise  = i_inc & ~r_prev & r_armed;
    assign o_score = r_score;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_score <= 8'h00;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_prev  <= i_inc;
            // armed once the request has been seen low since reset
            r_armed <= r_armed | ~i_inc;
            if (i_clear) begin
                r_score <= 8'h00;
            end else if (w_rise) begin
                r_score <= bcd_inc_sat(r_score);
            end
        end
    end

endmodule

// File: rtl/scoreboard_generator.sv
// Two-player score display: BCD counters plus a pixel generator that
// addresses an external 5x5 digit ROM and registers the lit pixel.
module scoreboard_generator
    import scoreboard_generator_pkg::*;
#(
    parameter int ROW_TOP = 16,
    parameter int P1_X    = 32,
    parameter int P2_X    = 192
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic       display_on,
    input  logic       inc_p1,
    input  logic       inc_p2,
    input  logic       clear_scores,
    output logic [3:0] digit,
    output logic [2:0] yofs,
    input  logic [4:0] bits,
    output logic       score_gfx,
    output logic [7:0] score1,
    output logic [7:0] score2
);

    localparam logic [8:0] ROW_FIRST = 9'(ROW_TOP);
    localparam logic [8:0] ROW_LAST  = 9'(ROW_TOP + ROW_H - 1);
    localparam logic [4:0] P1T_COL   = 5'(P1_X / CELL_W);
    localparam logic [4:0] P1O_COL   = 5'(P1_X / CELL_W + 1);
    localparam logic [4:0] P2T_COL   = 5'(P2_X / CELL_W);
    localparam logic [4:0] P2O_COL   = 5'(P2_X / CELL_W + 1);

    logic [7:0] w_score1;
    logic [7:0] w_score2;
    logic       w_in_row;
    logic [4:0] w_col;
    logic [2:0] w_xofs;
    cell_e      w_cell;
    logic [3:0] w_digit;
    logic       w_in_cell;
    logic       w_lit;
    logic       w_unused;
    logic       r_gfx;

    bcd_score_counter u_p1 (
        .clk     (clk),
        .i_rst_n (reset),
        .i_inc   (inc_p1),
        .i_clear (clear_scores),
        .o_score (w_score1)
    );

    bcd_score_counter u_p2 (
        .clk     (clk),
        .i_rst_n (reset),
        .i_inc   (inc_p2),
        .i_clear (clear_scores),
        .o_score (w_score2)
    );

    assign w_in_row = (vpos >= ROW_FIRST) && (vpos <= ROW_LAST);
    assign w_col    = hpos[8:4];
    assign w_xofs   = hpos[3:1];
    assign w_unused = hpos[0];

    always_comb begin
        w_cell = CELL_NONE;
        if (w_in_row) begin
            unique case (1'b1)
                (w_col == P1T_COL): w_cell = CELL_P1_TENS;
                (w_col == P1O_COL): w_cell = CELL_P1_ONES;
                (w_col == P2T_COL): w_cell = CELL_P2_TENS;
                (w_col == P2O_COL): w_cell = CELL_P2_ONES;
                default:            w_cell = CELL_NONE;
            endcase
        end
    end

    always_comb begin
        w_digit = BLANK_DIGIT;
        case (w_cell)
            CELL_P1_TENS: w_digit = w_score1[7:4];
            CELL_P1_ONES: w_digit = w_score1[3:0];
            CELL_P2_TENS: w_digit = w_score2[7:4];
            CELL_P2_ONES: w_digit = w_score2[3:0];
            default:      w_digit = BLANK_DIGIT;
        endcase
    end

    // leftmost ROM column is bits[4]; cell columns 10..15 stay dark
    always_comb begin
        w_lit = 1'b0;
        case (w_xofs)
            3'd0:    w_lit = bits[4];
            3'd1:    w_lit = bits[3];
            3'd2:    w_lit = bits[2];
            3'd3:    w_lit = bits[1];
            3'd4:    w_lit = bits[0];
            default: w_lit = 1'b0;
        endcase
    end

    assign w_in_cell = (w_cell != CELL_NONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_gfx <= 1'b0;
        end else begin
            r_gfx <= display_on & w_in_cell & w_lit;
        end
    end

    assign digit     = w_digit;
    assign yofs      = w_in_row ? vpos[3:1] : 3'd0;
    assign score_gfx = r_gfx;
    assign score1    = w_score1;
    assign score2    = w_score2;

endmodule

// File: tb/tb_scoreboard_generator.sv
// Self-checking bench for scoreboard_generator: vector table, directed
// corner sequences and random stimulus against an integer score model.
module tb_scoreboard_generator;

    localparam int ROW_TOP = 16;
    localparam int P1_X    = 32;
    localparam int P2_X    = 192;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] hpos;
    logic [8:0] vpos;
    logic       display_on;
    logic       inc_p1;
    logic       inc_p2;
    logic       clear_scores;
    logic [3:0] digit;
    logic [2:0] yofs;
    logic [4:0] bits;
    logic       score_gfx;
    logic [7:0] score1;
    logic [7:0] score2;

    int total = 0;
    int bad   = 0;

    int m_s1, m_s2;
    bit m_prev1, m_prev2, m_low1, m_low2, m_gfx;

    scoreboard_generator #(
        .ROW_TOP (ROW_TOP),
        .P1_X    (P1_X),
        .P2_X    (P2_X)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .hpos         (hpos),
        .vpos         (vpos),
        .display_on   (display_on),
        .inc_p1       (inc_p1),
        .inc_p2       (inc_p2),
        .clear_scores (clear_scores),
        .digit        (digit),
        .yofs         (yofs),
        .bits         (bits),
        .score_gfx    (score_gfx),
        .score1       (score1),
        .score2       (score2)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] rom_row(input logic [3:0] d, input logic [2:0] y);
        logic [24:0] w;
        case (d)
            4'd0: w = 25'b11111_10001_10001_10001_11111;
            4'd1: w = 25'b00100_01100_00100_00100_01110;
            4'd2: w = 25'b11111_00001_11111_10000_11111;
            4'd3: w = 25'b11111_00001_01111_00001_11111;
            4'd4: w = 25'b10001_10001_11111_00001_00001;
            4'd5: w = 25'b11111_10000_11111_00001_11111;
            4'd6: w = 25'b11111_10000_11111_10001_11111;
            4'd7: w = 25'b11111_00001_00010_00100_00100;
            4'd8: w = 25'b11111_10001_11111_10001_11111;
            4'd9: w = 25'b11111_10001_11111_00001_11111;
            default: w = '0;
        endcase
        if (y > 3'd4) return 5'b0;
        return w[24 - 5*y -: 5];
    endfunction

    assign bits = rom_row(digit, yofs);

    function automatic int bcd(input int s);
        return (s / 10) * 16 + (s % 10);
    endfunction

    function automatic void model_pix(input int h, input int v, input int s1,
                                      input int s2, output int d, output int y,
                                      output bit on);
        int base;
        int x;
        logic [4:0] r;
        d = 15; y = 0; on = 0; base = -1;
        if (v >= ROW_TOP && v < ROW_TOP + 10) begin
            y = (v - ROW_TOP) / 2;
            if (h >= P1_X && h < P1_X + 16) begin
                d = s1 / 10; base = P1_X;
            end else if (h >= P1_X + 16 && h < P1_X + 32) begin
                d = s1 % 10; base = P1_X + 16;
            end else if (h >= P2_X && h < P2_X + 16) begin
                d = s2 / 10; base = P2_X;
            end else if (h >= P2_X + 16 && h < P2_X + 32) begin
                d = s2 % 10; base = P2_X + 16;
            end
            if (base >= 0) begin
                x = (h - base) / 2;
                r = rom_row(4'(d), 3'(y));
                if (x < 5) on = r[4 - x];
            end
        end
    endfunction

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", n, act, exp);
        end
    endtask

    // advance one clock, updating the score model from the current inputs
    task automatic tick();
        int d, y;
        bit on;
        bit r1, r2;
        model_pix(int'(hpos), int'(vpos), m_s1, m_s2, d, y, on);
        if (!reset) begin
            m_s1 = 0; m_s2 = 0; m_gfx = 0;
            m_prev1 = 0; m_prev2 = 0; m_low1 = 0; m_low2 = 0;
        end else begin
            r1 = inc_p1 && !m_prev1 && m_low1;
            r2 = inc_p2 && !m_prev2 && m_low2;
            if (clear_scores) begin
                m_s1 = 0; m_s2 = 0;
            end else begin
                if (r1 && m_s1 < 99) m_s1++;
                if (r2 && m_s2 < 99) m_s2++;
            end
            m_gfx   = display_on && on;
            m_prev1 = inc_p1;
            m_prev2 = inc_p2;
            m_low1  = m_low1 || !inc_p1;
            m_low2  = m_low2 || !inc_p2;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 0; inc_p1 = 0; inc_p2 = 0; clear_scores = 0;
        tick(); tick();
        reset = 1;
    endtask

    task automatic pulse1();
        inc_p1 = 1; tick();
        inc_p1 = 0; tick();
    endtask

    typedef struct {
        bit       i1;
        bit       i2;
        bit       clr;
        int       e1;
        int       e2;
    } vec_t;

    vec_t vt[11];

    initial begin
        #10000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int d, y;
        bit on;

        vt[0]  = '{0, 0, 0, 'h00, 'h00};
        vt[1]  = '{1, 0, 0, 'h01, 'h00};
        vt[2]  = '{1, 0, 0, 'h01, 'h00};
        vt[3]  = '{0, 1, 0, 'h01, 'h01};
        vt[4]  = '{0, 0, 0, 'h01, 'h01};
        vt[5]  = '{1, 1, 0, 'h02, 'h02};
        vt[6]  = '{0, 0, 0, 'h02, 'h02};
        vt[7]  = '{0, 1, 1, 'h00, 'h00};
        vt[8]  = '{0, 1, 0, 'h00, 'h00};
        vt[9]  = '{1, 0, 0, 'h01, 'h00};
        vt[10] = '{0, 0, 1, 'h00, 'h00};

        m_s1 = 0; m_s2 = 0; m_gfx = 0;
        m_prev1 = 0; m_prev2 = 0; m_low1 = 0; m_low2 = 0;
        reset = 0; hpos = 0; vpos = 0; display_on = 0;
        inc_p1 = 0; inc_p2 = 0; clear_scores = 0;
        tick(); tick();
        chk("rst_s1", int'(score1), 'h00);
        chk("rst_s2", int'(score2), 'h00);
        chk("rst_gfx", int'(score_gfx), 0);

        // request held high through reset release must not count
        inc_p1 = 1; tick();
        reset = 1; tick(); tick();
        chk("held_at_release", int'(score1), 'h00);
        inc_p1 = 0; tick();
        inc_p1 = 1; tick();
        chk("count_after_low", int'(score1), 'h01);
        inc_p1 = 0; tick();

        do_reset();
        tick();
        foreach (vt[i]) begin
            inc_p1 = vt[i].i1; inc_p2 = vt[i].i2; clear_scores = vt[i].clr;
            tick();
            chk($sformatf("vec%0d_s1", i), int'(score1), vt[i].e1);
            chk($sformatf("vec%0d_s2", i), int'(score2), vt[i].e2);
        end
        inc_p1 = 0; inc_p2 = 0; clear_scores = 0;
        tick();

        do_reset();
        tick();
        repeat (12) pulse1();
        chk("twelve_s1", int'(score1), 'h12);
        chk("twelve_s2", int'(score2), 'h00);

        clear_scores = 1; tick(); clear_scores = 0;
        repeat (99) pulse1();
        chk("load99", int'(score1), 'h99);
        pulse1();
        chk("sat99", int'(score1), 'h99);

        clear_scores = 1; tick(); clear_scores = 0;
        repeat (9) pulse1();
        chk("load09", int'(score1), 'h09);
        pulse1();
        chk("carry10", int'(score1), 'h10);

        inc_p1 = 1;
        repeat (50) tick();
        inc_p1 = 0; tick();
        chk("held50", int'(score1), 'h11);

        // reset in the same cycle as a rising edge
        inc_p1 = 1; reset = 0; tick();
        chk("rst_wins", int'(score1), 'h00);
        reset = 1; inc_p1 = 0; tick();

        do_reset();
        tick();
        repeat (7) pulse1();
        vpos = 16; display_on = 1;
        for (int h = 48; h < 64; h++) begin
            hpos = 9'(h);
            #1;
            chk($sformatf("d7_digit_h%0d", h), int'(digit), 7);
            if (h == 48) chk("d7_yofs", int'(yofs), 0);
            tick();
            chk($sformatf("d7_gfx_h%0d", h), int'(score_gfx), (h <= 57) ? 1 : 0);
        end

        vpos = 26;
        for (int h = 0; h < 320; h++) begin
            hpos = 9'(h);
            #1;
            chk($sformatf("v26_digit_h%0d", h), int'(digit), 15);
            tick();
            chk($sformatf("v26_gfx_h%0d", h), int'(score_gfx), 0);
        end
        vpos = 16; display_on = 0;
        for (int h = 0; h < 320; h++) begin
            hpos = 9'(h);
            tick();
            chk($sformatf("doff_gfx_h%0d", h), int'(score_gfx), 0);
        end

        do_reset();
        tick();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 1) == 0) inc_p1 = ~inc_p1;
            if ($urandom_range(0, 1) == 0) inc_p2 = ~inc_p2;
            clear_scores = ($urandom_range(0, 299) == 0);
            reset        = ($urandom_range(0, 599) != 0);
            display_on   = ($urandom_range(0, 7) != 0);
            hpos         = 9'($urandom_range(P1_X - 8, P2_X + 40));
            vpos         = 9'($urandom_range(ROW_TOP - 4, ROW_TOP + 14));
            #1;
            model_pix(int'(hpos), int'(vpos), m_s1, m_s2, d, y, on);
            chk("rnd_digit", int'(digit), d);
            chk("rnd_yofs", int'(yofs), y);
            tick();
            chk("rnd_s1", int'(score1), bcd(m_s1));
            chk("rnd_s2", int'(score2), bcd(m_s2));
            chk("rnd_gfx", int'(score_gfx), int'(m_gfx));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
